heading_controller: RTL and testbench
=====================================

HEADING_CONTROLLER -- requirements
Module: heading_controller

Interface
REQ-001 The block SHALL have the following parameters:
- HEADING_BITS, default 4, heading width; 2^HEADING_BITS headings, minimum 3.
- TICK_CYCLES, default 12500000, clk cycles per game tick, minimum 2.
- CNT_W, default 24, tick counter width, at least ceil(log2(TICK_CYCLES)).
- COOLDOWN_TICKS, default 2, ticks of fire lockout after an accepted shot, range 0..255.
- START_HEADING, default 0, heading loaded at reset.

REQ-002 The block SHALL have the following ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  game running; low freezes tick counter and cooldown.
- rotate_left  in  1  level, rotate counter-clockwise request.
- rotate_right  in  1  level, rotate clockwise request.
- thrust  in  1  level, forward request.
- fire_req  in  1  level, shoot request.
- fire_ack  in  1  bullet spawner accepts shot.
- tick  out  1  one-cycle game-tick pulse.
- heading  out  HEADING_BITS  current heading; 0 = up, increasing clockwise.
- dir_code  out  4  8-way compass code {left,right,down,up}.
- move_pulse  out  1  one-cycle forward-step strobe.
- fire_valid  out  1  shot offered to spawner.
- fire_heading  out  HEADING_BITS  heading carried by offered shot.
- shot_count  out  8  accepted shots, wraps 255->0.

Function
REQ-003 The tick counter SHALL load TICK_CYCLES-1 and decrement by 1 per cycle while enable=1. It SHALL hold while enable=0. tick SHALL be 1 exactly in cycles where the counter is 0 and enable=1; the counter SHALL reload TICK_CYCLES-1 in the following cycle.
REQ-004 On a tick with rotate_right=1 and rotate_left=0, heading SHALL become heading+1 modulo 2^HEADING_BITS, visible the cycle after tick.
REQ-005 On a tick with rotate_left=1 and rotate_right=0, heading SHALL become heading-1 modulo 2^HEADING_BITS (0 wraps to all-ones). Both high or both low SHALL leave heading unchanged.
REQ-006 Rotation SHALL occur only on tick cycles; request levels at other cycles SHALL be ignored.
REQ-007 dir_code SHALL be combinational from octant = heading[HEADING_BITS-1:HEADING_BITS-3], mapping octants 0..7 to 0001, 0101, 0100, 0110, 0010, 1010, 1000, 1001.
REQ-008 move_pulse SHALL be registered: 1 for exactly one cycle, the cycle after a tick on which thrust=1; 0 otherwise.
REQ-009 The fire FSM SHALL have states IDLE, PENDING and COOLDOWN, with transitions:
- IDLE -> PENDING: on a tick with fire_req=1; fire_heading latches the pre-rotation heading of that tick.
- PENDING: fire_valid=1 and fire_heading stable until fire_ack=1 is sampled; shot_count increments on that cycle.
- PENDING -> COOLDOWN: on fire_ack=1, cooldown loaded with COOLDOWN_TICKS.
- PENDING -> IDLE: on fire_ack=1 when COOLDOWN_TICKS=0.
- COOLDOWN: cooldown decrements by 1 on each tick; -> IDLE on the tick that decrements it from 1 to 0.
REQ-010 fire_valid SHALL be 1 only in PENDING. fire_ack outside PENDING SHALL be ignored. fire_req outside IDLE, or off-tick, SHALL be ignored (no queuing).
REQ-011 PENDING SHALL be held and the handshake SHALL complete regardless of enable.
REQ-012 fire_ack asserted in the same cycle PENDING is entered SHALL be accepted only from the next cycle, i.e. at the first cycle fire_valid=1.
REQ-013 Rotation and fire SHALL be independent: a tick may rotate, request fire and pulse move simultaneously.

Reset
REQ-014 While reset=1 at a clk edge:
- counter = TICK_CYCLES-1; heading = START_HEADING.
- fire FSM = IDLE; cooldown = 0; fire_heading = 0; shot_count = 0.
- tick, move_pulse and fire_valid = 0.
REQ-015 Reset SHALL override all other inputs, including mid-handshake (PENDING abandoned, no shot_count increment) and mid-cooldown.

Verification (TICK_CYCLES=4, HEADING_BITS=4, COOLDOWN_TICKS=2, START_HEADING=0)
REQ-016 Release reset with enable=1 -> tick high at cycles 4, 8, 12 after release; heading=0, dir_code=0001.
REQ-017 rotate_left held for 1 tick -> heading=15, dir_code=1001. Then rotate_right held for 3 ticks -> heading=2, dir_code=0101. Both held -> heading unchanged.
REQ-018 fire_req held, heading=5, fire_ack tied high -> fire_valid for 1 cycle, fire_heading=5, shot_count=1. Next acceptance SHALL NOT occur before the 3rd tick after ack; shot_count=2 after it.
REQ-019 fire_req pulse on tick, fire_ack withheld 20 cycles with enable toggled low -> fire_valid stays 1, fire_heading stable; completes on ack.
REQ-020 reset asserted while fire_valid=1 -> next cycle fire_valid=0, shot_count=0, heading=0, FSM IDLE.
REQ-021 thrust held, enable low for 6 cycles mid-period -> no tick or move_pulse during freeze; tick resumes after the remaining count elapses.

Source files
------------

// File: rtl/heading_controller.sv
// heading_controller
//   Ship heading / thrust / fire controller for a tick-based arcade game.
//   A free-running tick divider (frozen while enable=0) paces rotation,
//   forward steps and shot requests. Shots go through a small
//   IDLE/PENDING/COOLDOWN handshake FSM towards a bullet spawner.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   enable            game running; low freezes tick divider and cooldown
//   rotate_left/right level rotation requests, sampled on ticks only
//   thrust            level forward request, sampled on ticks only
//   fire_req          level shoot request, sampled on ticks in IDLE only
//   fire_ack          spawner accepts the offered shot (PENDING only)
//   tick              one-cycle game-tick pulse (combinational)
//   heading           current heading, 0 = up, increasing clockwise
//   dir_code          8-way compass code {left,right,down,up}
//   move_pulse        one-cycle strobe the cycle after a thrust tick
//   fire_valid        shot offered to spawner
//   fire_heading      heading carried by the offered shot
//   shot_count        accepted shots, wraps at 8 bits
module heading_controller #(
    parameter int HEADING_BITS   = 4,
    parameter int TICK_CYCLES    = 12500000,
    parameter int CNT_W          = 24,
    parameter int COOLDOWN_TICKS = 2,
    parameter int START_HEADING  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    rotate_left,
    input  logic                    rotate_right,
    input  logic                    thrust,
    input  logic                    fire_req,
    input  logic                    fire_ack,
    output logic                    tick,
    output logic [HEADING_BITS-1:0] heading,
    output logic [3:0]              dir_code,
    output logic                    move_pulse,
    output logic                    fire_valid,
    output logic [HEADING_BITS-1:0] fire_heading,
    output logic [7:0]              shot_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_COOLDOWN = 2'd2
    } fire_state_e;

    localparam logic [CNT_W-1:0]        CNT_RELOAD = CNT_W'(TICK_CYCLES - 1);
    localparam logic [HEADING_BITS-1:0] HDG_START  = HEADING_BITS'(START_HEADING);
    localparam logic [7:0]              CD_LOAD    = 8'(COOLDOWN_TICKS);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [HEADING_BITS-1:0] heading_q, heading_d;
    logic                    move_pulse_q, move_pulse_d;
    fire_state_e             state_q, state_d;
    logic [7:0]              cooldown_q, cooldown_d;
    logic [HEADING_BITS-1:0] fire_heading_q, fire_heading_d;
    logic [7:0]              shot_count_q, shot_count_d;
    logic [2:0]              octant;

    // Gated with reset so no tick escapes during the reset cycle itself.
    assign tick = enable && (cnt_q == '0) && !reset;

    always_comb begin
        cnt_d          = cnt_q;
        heading_d      = heading_q;
        move_pulse_d   = tick && thrust;
        state_d        = state_q;
        cooldown_d     = cooldown_q;
        fire_heading_d = fire_heading_q;
        shot_count_d   = shot_count_q;

        if (enable) begin
            cnt_d = (cnt_q == '0) ? CNT_RELOAD : cnt_q - CNT_W'(1);
        end

        if (tick) begin
            if (rotate_right && !rotate_left) begin
                heading_d = heading_q + HEADING_BITS'(1);
            end else if (rotate_left && !rotate_right) begin
                heading_d = heading_q - HEADING_BITS'(1);
            end
        end

        // PENDING ignores enable: the handshake completes even while frozen.
        unique case (state_q)
            ST_IDLE: begin
                if (tick && fire_req) begin
                    state_d        = ST_PENDING;
                    fire_heading_d = heading_q;  // pre-rotation heading
                end
            end
            ST_PENDING: begin
                if (fire_ack) begin
                    shot_count_d = shot_count_q + 8'd1;
                    if (COOLDOWN_TICKS == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_COOLDOWN;
                        cooldown_d = CD_LOAD;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (tick) begin
                    cooldown_d = cooldown_q - 8'd1;
                    if (cooldown_q == 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q          <= CNT_RELOAD;
            heading_q      <= HDG_START;
            move_pulse_q   <= 1'b0;
            state_q        <= ST_IDLE;
            cooldown_q     <= 8'd0;
            fire_heading_q <= '0;
            shot_count_q   <= 8'd0;
        end else begin
            cnt_q          <= cnt_d;
            heading_q      <= heading_d;
            move_pulse_q   <= move_pulse_d;
            state_q        <= state_d;
            cooldown_q     <= cooldown_d;
            fire_heading_q <= fire_heading_d;
            shot_count_q   <= shot_count_d;
        end
    end

    // Top three heading bits select one of eight compass octants.
    assign octant = heading_q[HEADING_BITS-1 -: 3];

    always_comb begin
        dir_code = 4'b0001;
        unique case (octant)
            3'd0: dir_code = 4'b0001;
            3'd1: dir_code = 4'b0101;
            3'd2: dir_code = 4'b0100;
            3'd3: dir_code = 4'b0110;
            3'd4: dir_code = 4'b0010;
            3'd5: dir_code = 4'b1010;
            3'd6: dir_code = 4'b1000;
            3'd7: dir_code = 4'b1001;
            default: dir_code = 4'b0001;
        endcase
    end

    assign heading      = heading_q;
    assign move_pulse   = move_pulse_q;
    assign fire_valid   = (state_q == ST_PENDING);
    assign fire_heading = fire_heading_q;
    assign shot_count   = shot_count_q;

endmodule

// File: tb/tb_heading_controller.sv
module tb_heading_controller;

    logic       clk = 1'b0;
    logic       reset, enable, rotate_left, rotate_right, thrust, fire_req, fire_ack;
    logic       tick, move_pulse, fire_valid;
    logic [3:0] heading, dir_code, fire_heading;
    logic [7:0] shot_count;

    int n_assert = 0;
    int n_fail   = 0;

    heading_controller #(
        .HEADING_BITS(4), .TICK_CYCLES(4), .CNT_W(4),
        .COOLDOWN_TICKS(2), .START_HEADING(0)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .rotate_left(rotate_left), .rotate_right(rotate_right),
        .thrust(thrust), .fire_req(fire_req), .fire_ack(fire_ack),
        .tick(tick), .heading(heading), .dir_code(dir_code),
        .move_pulse(move_pulse), .fire_valid(fire_valid),
        .fire_heading(fire_heading), .shot_count(shot_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next tick cycle (bounded); leaves us inside that cycle.
    task automatic next_tick();
        int n = 0;
        while (tick !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        chk("next_tick", tick, 1);
    endtask

    initial begin
        int ticks_seen;
        reset = 1; enable = 1; rotate_left = 0; rotate_right = 0;
        thrust = 0; fire_req = 0; fire_ack = 0;
        step(); step(); step();
        chk("rst_tick", tick, 0);
        chk("rst_heading", heading, 0);
        chk("rst_dir", dir_code, 4'b0001);
        chk("rst_move", move_pulse, 0);
        chk("rst_fv", fire_valid, 0);
        chk("rst_fh", fire_heading, 0);
        chk("rst_shots", shot_count, 0);

        // Tick cadence: release cycle is cycle 1, ticks at cycles 4, 8, 12.
        reset = 0;
        chk("cad_c1", tick, 0);
        for (int i = 2; i <= 12; i++) begin
            step();
            chk($sformatf("cad_c%0d", i), tick, (i % 4 == 0) ? 1 : 0);
        end
        step();
        chk("cad_heading", heading, 0);
        chk("cad_dir", dir_code, 4'b0001);

        // Rotate left one tick: 0 -> 15.
        next_tick();
        rotate_left = 1;
        step();
        rotate_left = 0;
        chk("rl_heading", heading, 15);
        chk("rl_dir", dir_code, 4'b1001);

        // Rotate right held; off-tick cycles must not rotate.
        rotate_right = 1;
        step(); step();
        chk("rr_offtick", heading, 15);
        for (int i = 0; i < 3; i++) begin
            next_tick();
            step();
        end
        rotate_right = 0;
        chk("rr_heading", heading, 2);
        chk("rr_dir", dir_code, 4'b0101);

        // Both held with thrust: no rotation, one move pulse.
        rotate_left = 1; rotate_right = 1; thrust = 1;
        next_tick();
        step();
        rotate_left = 0; rotate_right = 0; thrust = 0;
        chk("both_heading", heading, 2);
        chk("move_on", move_pulse, 1);
        step();
        chk("move_off", move_pulse, 0);

        // Bring heading to 5.
        rotate_right = 1;
        for (int i = 0; i < 3; i++) begin
            next_tick();
            step();
        end
        rotate_right = 0;
        chk("h5_heading", heading, 5);
        chk("h5_dir", dir_code, 4'b0100);

        // Fire with ack tied high; ack on entry cycle is not yet accepted.
        fire_req = 1; fire_ack = 1;
        next_tick();
        step();
        chk("f1_valid", fire_valid, 1);
        chk("f1_heading", fire_heading, 5);
        chk("f1_shots_pre", shot_count, 0);
        step();
        chk("f1_shots", shot_count, 1);
        chk("f1_valid_off", fire_valid, 0);
        ticks_seen = 0;
        for (int n = 0; n < 30 && fire_valid !== 1'b1; n++) begin
            if (tick === 1'b1) ticks_seen++;
            step();
        end
        chk("f2_valid", fire_valid, 1);
        chk("f2_ticks", ticks_seen, 3);
        chk("f2_cd_shots", shot_count, 1);
        chk("f2_heading", fire_heading, 5);
        step();
        fire_req = 0; fire_ack = 0;
        chk("f2_shots", shot_count, 2);

        // Drain cooldown (two ticks).
        next_tick(); step();
        next_tick(); step();
        chk("cd_idle", fire_valid, 0);

        // Pending held over 20 cycles with enable toggling and rotation.
        next_tick();
        fire_req = 1;
        step();
        fire_req = 0;
        chk("p_valid", fire_valid, 1);
        chk("p_heading", fire_heading, 5);
        rotate_right = 1;
        for (int i = 0; i < 20; i++) begin
            enable = (i % 3 != 0);
            step();
            chk($sformatf("p_hold_v%0d", i), fire_valid, 1);
            chk($sformatf("p_hold_h%0d", i), fire_heading, 5);
        end
        rotate_right = 0;
        enable = 0; fire_ack = 1;
        step();
        fire_ack = 0; enable = 1;
        chk("p_shots", shot_count, 3);
        chk("p_valid_off", fire_valid, 0);

        // Reset mid-handshake.
        next_tick(); step();
        next_tick(); step();
        fire_req = 1;
        next_tick();
        step();
        fire_req = 0;
        chk("r_valid_pre", fire_valid, 1);
        reset = 1; fire_ack = 1;
        step();
        reset = 0; fire_ack = 0;
        chk("r_valid", fire_valid, 0);
        chk("r_shots", shot_count, 0);
        chk("r_heading", heading, 0);
        chk("r_fh", fire_heading, 0);
        chk("r_tick", tick, 0);

        // Freeze mid-period with thrust held.
        thrust = 1;
        step();
        chk("fz_pre", tick, 0);
        enable = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("fz_tick%0d", i), tick, 0);
            chk($sformatf("fz_move%0d", i), move_pulse, 0);
        end
        enable = 1;
        step();
        chk("fz_res1", tick, 0);
        step();
        chk("fz_res2", tick, 1);
        chk("fz_move_pre", move_pulse, 0);
        step();
        chk("fz_move", move_pulse, 1);
        chk("fz_tick_off", tick, 0);
        thrust = 0;
        step();
        chk("fz_move_off", move_pulse, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
